// File: rtl/key_event_decoder_pkg.sv
// key_event_decoder_pkg
//   Shared definitions for the key event decoder: FSM state encodings,
//   default timing constants (milliseconds at 1 kHz), and the event bundle.
package key_event_decoder_pkg;

  // 3-bit state encodings; the numeric values are shared with other key-handling blocks.
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_PRESS1    = 3'd1,
    ST_WAIT2     = 3'd2,
    ST_PRESS2    = 3'd3,
    ST_LONG_HOLD = 3'd4
  } state_t;

  localparam int LONG_MS_DEF   = 1000;
  localparam int DCLICK_MS_DEF = 300;
  localparam int REPEAT_MS_DEF = 200;
  localparam int CNT_W_DEF     = 11;

  // At most one field is ever set in a given cycle.
  typedef struct packed {
    logic short_p;
    logic double_p;
    logic long_p;
    logic repeat_p;
  } evt_t;

endpackage

// File: rtl/key_event_decoder_edge_det.sv
// key_edge_det
//   Two-FF level/edge stage for a debounced key level.
//   Ports:
//     i_clk    in  clock
//     i_rst    in  synchronous reset, active-high
//     i_level  in  debounced level, 1 = pressed
//     o_rise   out level went 0 -> 1 (combinational from the two FFs)
//     o_fall   out level went 1 -> 0
//   Both stages reset to 1 (pressed). A key held through reset therefore looks
//   like an unchanged level: no rise is seen until it is released and pressed
//   again. A key that is up during reset yields a single fall, which idle
//   consumers ignore.
module key_edge_det (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_level,
  output logic o_rise,
  output logic o_fall
);

  logic r_key_q;
  logic r_key_q_d;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_key_q   <= 1'b1;
      r_key_q_d <= 1'b1;
    end else begin
      r_key_q   <= i_level;
      r_key_q_d <= r_key_q;
    end
  end

  assign o_rise =  r_key_q & ~r_key_q_d;
  assign o_fall = ~r_key_q &  r_key_q_d;

endmodule

// File: rtl/key_event_decoder.sv
// key_event_decoder
//   Classifies key gestures on a 1 kHz clock (1 tick = 1 ms) into short press,
//   double click, long press and auto-repeat, and emits one-cycle pulses.
//   Ports:
//     clk_1KHz      in   system clock, rising edge
//     rst           in   synchronous reset, active-high
//     key_level     in   debounced key level, 1 = pressed
//     short_pulse   out  single short press confirmed
//     double_pulse  out  double click confirmed
//     long_pulse    out  long press threshold reached
//     repeat_pulse  out  periodic repeat while long-held
//     busy          out  FSM not in IDLE
//   All outputs are registered alongside the state, so a pulse is high in the
//   first cycle of the state the deciding transition lands in.
module key_event_decoder
  import key_event_decoder_pkg::*;
#(
  parameter int LONG_MS   = LONG_MS_DEF,
  parameter int DCLICK_MS = DCLICK_MS_DEF,
  parameter int REPEAT_MS = REPEAT_MS_DEF,
  parameter int CNT_W     = CNT_W_DEF
) (
  input  logic clk_1KHz,
  input  logic rst,
  input  logic key_level,
  output logic short_pulse,
  output logic double_pulse,
  output logic long_pulse,
  output logic repeat_pulse,
  output logic busy
);

  localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_MS - 1);
  localparam logic [CNT_W-1:0] DCLICK_LAST = CNT_W'(DCLICK_MS - 1);
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_MS - 1);

  logic             w_rise;
  logic             w_fall;
  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_cnt_clr;
  evt_t             r_evt;
  evt_t             w_evt_nxt;
  logic             r_busy;

  key_edge_det u_edge (
    .i_clk   (clk_1KHz),
    .i_rst   (rst),
    .i_level (key_level),
    .o_rise  (w_rise),
    .o_fall  (w_fall)
  );

  // Next state / event. Edge checks precede timeouts so a release (or a second
  // press) landing on the timeout cycle wins.
  always_comb begin
    w_state_nxt = r_state;
    w_evt_nxt   = '0;
    w_cnt_clr   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_rise) w_state_nxt = ST_PRESS1;
      end
      ST_PRESS1: begin
        if (w_fall) begin
          w_state_nxt = ST_WAIT2;
        end else if (r_cnt == LONG_LAST) begin
          w_state_nxt      = ST_LONG_HOLD;
          w_evt_nxt.long_p = 1'b1;
        end
      end
      ST_WAIT2: begin
        if (w_rise) begin
          w_state_nxt = ST_PRESS2;
        end else if (r_cnt == DCLICK_LAST) begin
          w_state_nxt       = ST_IDLE;
          w_evt_nxt.short_p = 1'b1;
        end
      end
      ST_PRESS2: begin
        // Second press is not timed: no long press from here.
        if (w_fall) begin
          w_state_nxt        = ST_IDLE;
          w_evt_nxt.double_p = 1'b1;
        end
      end
      ST_LONG_HOLD: begin
        if (w_fall) begin
          w_state_nxt = ST_IDLE;
        end else if (r_cnt == REPEAT_LAST) begin
          w_evt_nxt.repeat_p = 1'b1;
          w_cnt_clr          = 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Shared timer: cleared on any state change or repeat restart, counts only in
  // timed states. Each compare value ends the count, so it never wraps.
  always_comb begin
    w_cnt_nxt = r_cnt;
    if (w_state_nxt != r_state || w_cnt_clr)
      w_cnt_nxt = '0;
    else if (r_state == ST_PRESS1 || r_state == ST_WAIT2 || r_state == ST_LONG_HOLD)
      w_cnt_nxt = r_cnt + 1'b1;
  end

  always_ff @(posedge clk_1KHz) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_evt   <= '0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_evt   <= w_evt_nxt;
      r_busy  <= (w_state_nxt != ST_IDLE);
    end
  end

  assign short_pulse  = r_evt.short_p;
  assign double_pulse = r_evt.double_p;
  assign long_pulse   = r_evt.long_p;
  assign repeat_pulse = r_evt.repeat_p;
  assign busy         = r_busy;

endmodule

// File: tb/tb_key_event_decoder.sv
// Directed bench for key_event_decoder with LONG_MS=20, DCLICK_MS=10, REPEAT_MS=5.
// Step n = the n-th rising edge of a scenario; key_level is driven before the
// edge and outputs are sampled 1 time unit after it. A level first seen at
// step 1 becomes a rise in the FSM at step 2 (PRESS1 entry), so expected pulse
// steps below are hand-derived from that two-cycle input latency.
// Observed vector = {short, double, long, repeat, busy}.
module tb_key_event_decoder;

  logic clk;
  logic rst;
  logic key_level;
  logic short_pulse, double_pulse, long_pulse, repeat_pulse, busy;

  int         vecs = 0;
  int         errs = 0;
  logic [4:0] obs;
  logic [4:0] exp;

  key_event_decoder #(
    .LONG_MS   (20),
    .DCLICK_MS (10),
    .REPEAT_MS (5),
    .CNT_W     (11)
  ) dut (
    .clk_1KHz     (clk),
    .rst          (rst),
    .key_level    (key_level),
    .short_pulse  (short_pulse),
    .double_pulse (double_pulse),
    .long_pulse   (long_pulse),
    .repeat_pulse (repeat_pulse),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input logic lvl);
    key_level = lvl;
    @(posedge clk);
    #1;
    obs = {short_pulse, double_pulse, long_pulse, repeat_pulse, busy};
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      step(1'b0);
      exp = 5'b0;
      vecs++;
      if (obs !== exp) begin errs++; $display("FAIL reset step %0d: got %b want %b", i, obs, exp); end
    end
    rst = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      step(1'b0);
      exp = 5'b0;
      vecs++;
      if (obs !== exp) begin errs++; $display("FAIL idle step %0d: got %b want %b", i, obs, exp); end
    end
  endtask

  // High 5 -> WAIT2 at step 7, short_pulse 10 cycles later at 17.
  task automatic test_short();
    for (int i = 1; i <= 20; i++) begin
      step(i <= 5);
      exp = {(i == 17), 1'b0, 1'b0, 1'b0, (i >= 2 && i <= 16)};
      vecs++;
      if (obs !== exp) begin errs++; $display("FAIL short step %0d: got %b want %b", i, obs, exp); end
    end
  endtask

  // High 5, low 4, high 3: PRESS2 at 11, release seen -> double at 14.
  task automatic test_double();
    for (int i = 1; i <= 18; i++) begin
      step(i <= 5 || (i >= 10 && i <= 12));
      exp = {1'b0, (i == 14), 1'b0, 1'b0, (i >= 2 && i <= 13)};
      vecs++;
      if (obs !== exp) begin errs++; $display("FAIL double step %0d: got %b want %b", i, obs, exp); end
    end
  endtask

  // PRESS1 at 2, long at 22, repeats at 27/32/37/42; level dropped after step 41
  // reaches the FSM at 43, just after the fourth repeat. No pulse on release.
  task automatic test_long_repeat();
    for (int i = 1; i <= 46; i++) begin
      step(i <= 41);
      exp = {1'b0, 1'b0, (i == 22),
             (i == 27 || i == 32 || i == 37 || i == 42),
             (i >= 2 && i <= 42)};
      vecs++;
      if (obs !== exp) begin errs++; $display("FAIL long step %0d: got %b want %b", i, obs, exp); end
    end
  endtask

  // Release landing on the long timeout cycle: fall wins -> WAIT2 at 22, short at 32.
  // One cycle longer: long at 22, release ends LONG_HOLD at 23 with no pulse.
  task automatic test_long_boundary();
    for (int i = 1; i <= 35; i++) begin
      step(i <= 20);
      exp = {(i == 32), 1'b0, 1'b0, 1'b0, (i >= 2 && i <= 31)};
      vecs++;
      if (obs !== exp) begin errs++; $display("FAIL long_edge_short step %0d: got %b want %b", i, obs, exp); end
    end
    for (int i = 1; i <= 25; i++) begin
      step(i <= 21);
      exp = {1'b0, 1'b0, (i == 22), 1'b0, (i >= 2 && i <= 22)};
      vecs++;
      if (obs !== exp) begin errs++; $display("FAIL long_edge_long step %0d: got %b want %b", i, obs, exp); end
    end
  endtask

  // Second press seen in the 10th WAIT2 cycle (cnt=9): rise beats timeout.
  // PRESS2 at 17, release after 18 -> double at 20.
  task automatic test_double_boundary();
    for (int i = 1; i <= 23; i++) begin
      step(i <= 5 || (i >= 16 && i <= 18));
      exp = {1'b0, (i == 20), 1'b0, 1'b0, (i >= 2 && i <= 19)};
      vecs++;
      if (obs !== exp) begin errs++; $display("FAIL double_edge step %0d: got %b want %b", i, obs, exp); end
    end
  endtask

  // Key held through reset is ignored until released and pressed again.
  task automatic test_reset_held();
    rst = 1'b1;
    for (int i = 1; i <= 2; i++) begin
      step(1'b1);
      exp = 5'b0;
      vecs++;
      if (obs !== exp) begin errs++; $display("FAIL rst_held_in step %0d: got %b want %b", i, obs, exp); end
    end
    rst = 1'b0;
    for (int i = 1; i <= 33; i++) begin
      step(i <= 30);
      exp = 5'b0;
      vecs++;
      if (obs !== exp) begin errs++; $display("FAIL rst_held_ignored step %0d: got %b want %b", i, obs, exp); end
    end
    for (int i = 1; i <= 20; i++) begin
      step(i <= 5);
      exp = {(i == 17), 1'b0, 1'b0, 1'b0, (i >= 2 && i <= 16)};
      vecs++;
      if (obs !== exp) begin errs++; $display("FAIL rst_held_repress step %0d: got %b want %b", i, obs, exp); end
    end
  endtask

  // Reset during WAIT2 drops the pending short press.
  task automatic test_reset_wait2();
    for (int i = 1; i <= 10; i++) begin
      step(i <= 5);
      exp = {4'b0, (i >= 2)};
      vecs++;
      if (obs !== exp) begin errs++; $display("FAIL rst_wait2_pre step %0d: got %b want %b", i, obs, exp); end
    end
    rst = 1'b1;
    step(1'b0);
    exp = 5'b0;
    vecs++;
    if (obs !== exp) begin errs++; $display("FAIL rst_wait2_busy: got %b want %b", obs, exp); end
    rst = 1'b0;
    for (int i = 1; i <= 15; i++) begin
      step(1'b0);
      exp = 5'b0;
      vecs++;
      if (obs !== exp) begin errs++; $display("FAIL rst_wait2_post step %0d: got %b want %b", i, obs, exp); end
    end
  endtask

  // New press driven right after short_pulse at 17: second gesture is offset by 17.
  task automatic test_back_to_back();
    for (int i = 1; i <= 37; i++) begin
      step(i <= 5 || (i >= 18 && i <= 22));
      exp = {(i == 17 || i == 34), 1'b0, 1'b0, 1'b0,
             ((i >= 2 && i <= 16) || (i >= 19 && i <= 33))};
      vecs++;
      if (obs !== exp) begin errs++; $display("FAIL b2b step %0d: got %b want %b", i, obs, exp); end
    end
  endtask

  initial begin
    rst       = 1'b1;
    key_level = 1'b0;
    test_reset();
    test_short();
    test_double();
    test_long_repeat();
    test_long_boundary();
    test_double_boundary();
    test_reset_held();
    test_reset_wait2();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
